// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative MULT/MULTU/DIV/DIVU unit with stall/ready handshake; MD_FAST_MULT_EN selects a single-cycle multiply
module md_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_i,
    input  logic             sign_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic op, neg_q, neg_r;
    logic [WIDTH-1:0] ma, mb, acc, lo_r, abs_a, abs_b, nacc, nlo, rq, rr;
    logic [WIDTH:0] msum, dtrial;
    logic [2*WIDTH-1:0] prod;
    assign busy_o  = state == CALC;
    assign ready_o = state == DONE;
    assign stall_o = busy_o | (state == IDLE & start_i & ~annul_i);
`ifdef MD_FAST_MULT_EN
    logic [2*WIDTH-1:0] fprod;
    // Whole product in one cycle; sign-extending both operands makes one unsigned multiply serve both modes
    always_comb fprod = {{WIDTH{sign_i & a_i[WIDTH-1]}}, a_i} * {{WIDTH{sign_i & b_i[WIDTH-1]}}, b_i};
`endif
    // Operand magnitudes, one shift-add / restoring-divide step, and the sign fixup of the final step
    always_comb begin
        abs_a  = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
        abs_b  = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;
        msum   = {1'b0, acc} + (lo_r[0] ? {1'b0, ma} : '0);
        dtrial = {acc, lo_r[WIDTH-1]} - {1'b0, mb};
        nacc   = op ? (dtrial[WIDTH] ? {acc[WIDTH-2:0], lo_r[WIDTH-1]} : dtrial[WIDTH-1:0]) : msum[WIDTH:1];
        nlo    = op ? {lo_r[WIDTH-2:0], ~dtrial[WIDTH]} : {msum[0], lo_r[WIDTH-1:1]};
        prod   = neg_q ? -{nacc, nlo} : {nacc, nlo};
        rq     = (mb == '0) ? '1 : (neg_q ? -nlo : nlo);
        rr     = neg_r ? -nacc : nacc;
    end
    // Control FSM plus iteration registers; results are committed on the last CALC step
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            lo_r  <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
            dbz_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && !annul_i) begin
`ifdef MD_FAST_MULT_EN
                    if (!op_i) begin
                        state <= DONE;
                        hi_o  <= fprod[2*WIDTH-1:WIDTH];
                        lo_o  <= fprod[WIDTH-1:0];
                        dbz_o <= 1'b0;
                    end else begin
                        state <= CALC;
                    end
`else
                    state <= CALC;
`endif
                    cnt   <= '0;
                    op    <= op_i;
                    neg_q <= sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_r <= sign_i & a_i[WIDTH-1];
                    ma    <= abs_a;
                    mb    <= abs_b;
                    acc   <= '0;
                    lo_r  <= op_i ? abs_a : abs_b;
                end
                CALC: if (annul_i) begin
                    state <= IDLE;
                end else begin
                    acc <= nacc;
                    lo_r <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                        hi_o  <= op ? rr : prod[2*WIDTH-1:WIDTH];
                        lo_o  <= op ? rq : prod[WIDTH-1:0];
                        dbz_o <= op & (mb == '0);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
